// File: rtl/case2_stim_checker.sv
// case2_stim_checker: on-chip self-test initiator for the 5-input case2 block.
// Sweeps all 32 input vectors on {a,b,c,d,e}, waits SETTLE_CYCLES clocks per
// vector and then samples {x_in,y_in,z_in}. Each sample is compared against a
// golden model and folded into a 16-bit MISR. The block reports the error
// count, the first failing vector and the signature.
module case2_stim_checker #(
    // Clocks a vector is held before sampling; legal range 1..15.
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] MISR_SEED     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        x_in,
    input  logic        y_in,
    input  logic        z_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_cnt,
    output logic [4:0]  first_fail,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle counter terminal value; a 4-bit counter covers the full 1..15 range.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] VEC_LAST = 5'd31;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    state_t      state, state_nxt;
    logic [4:0]  vec;
    logic [3:0]  cnt;

    logic [2:0]  resp_obs;
    logic [2:0]  resp_exp;
    logic        mismatch;
    logic        last_vec;
    logic        settle_end;
    logic [15:0] sig_nxt;

    // Reference behaviour of case2 for one vector, packed as {x,y,z}.
    function automatic logic [2:0] golden(input logic [4:0] v);
        logic va, vb, vc, vd, ve;
        logic gx, gy;
        {va, vb, vc, vd, ve} = v;
        gx = va & vb & (vc | vd) & (va ^ ve);
        gy = ~(va & vb & vc & vd & ve);
        return {gx, gy, gy};
    endfunction

    // Compare, MISR next value and sequencing conditions for the current vector.
    always_comb begin
        resp_obs   = {x_in, y_in, z_in};
        resp_exp   = golden(vec);
        mismatch   = (resp_obs != resp_exp);
        last_vec   = (vec == VEC_LAST);
        settle_end = (cnt == CNT_LAST);
        sig_nxt    = {signature[14:0], 1'b0}
                   ^ (signature[15] ? MISR_POLY : 16'h0000)
                   ^ {13'b0, resp_obs};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_end) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: vector drive, settle counter, error tracking, MISR and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            cnt             <= '0;
            {a, b, c, d, e} <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_fail      <= '0;
            signature       <= MISR_SEED;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec             <= '0;
                        cnt             <= '0;
                        {a, b, c, d, e} <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_fail      <= '0;
                        signature       <= MISR_SEED;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                end
                SAMPLE: begin
                    signature <= sig_nxt;
                    if (mismatch) begin
                        err_cnt <= err_cnt + 6'd1;
                        // err_cnt still zero means this is the sweep's first failure.
                        if (err_cnt == 6'd0) first_fail <= vec;
                    end
                    if (last_vec) begin
                        // Final vector: results settle in this same edge, so pass
                        // folds in the current compare rather than the old count.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_cnt == 6'd0) && !mismatch;
                    end else begin
                        vec             <= vec + 5'd1;
                        {a, b, c, d, e} <= vec + 5'd1;
                        cnt             <= '0;
                    end
                end
                DONE: begin
                    // Results and last vector simply hold; done drops via the default.
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_case2_stim_checker.sv
// Directed bench for case2_stim_checker: a behavioural case2 stand-in with
// selectable stuck faults answers the stimulus, and sweep results are compared
// against hand-derived counts plus a bench-side MISR model.
module tb_case2_stim_checker;

    localparam int          SC      = 2;
    localparam logic [15:0] SEED    = 16'hFFFF;
    localparam int          SWEEP   = 1 + 32 * (SC + 1);
    localparam int          TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        x_in, y_in, z_in;
    logic        a, b, c, d, e;
    logic        busy, done, pass;
    logic [5:0]  err_cnt;
    logic [4:0]  first_fail;
    logic [15:0] signature;

    // 0: correct, 1: z stuck 0, 2: x stuck 0, 3: y stuck 1
    int mode = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    case2_stim_checker #(.SETTLE_CYCLES(SC), .MISR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .signature(signature)
    );

    // Behavioural block under test, {x,y,z} for vector v under fault mode m.
    function automatic logic [2:0] bench_resp(input logic [4:0] v, input int m);
        logic xe, ye;
        xe = v[4] & v[3] & (v[2] | v[1]) & ~v[0];
        ye = (v != 5'd31);
        case (m)
            1:       return {xe, ye, 1'b0};
            2:       return {1'b0, ye, ye};
            3:       return {xe, 1'b1, ye};
            default: return {xe, ye, ye};
        endcase
    endfunction

    assign {x_in, y_in, z_in} = bench_resp({a, b, c, d, e}, mode);

    function automatic logic [15:0] misr_model(input int m);
        logic [15:0] s;
        logic [2:0]  r;
        s = SEED;
        for (int v = 0; v < 32; v++) begin
            r = bench_resp(5'(v), m);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, r};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"},  {27'b0, a, b, c, d, e}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_pass"}, {31'b0, pass}, 32'd0);
        chk({tag, "_err"},  {26'b0, err_cnt}, 32'd0);
        chk({tag, "_ff"},   {27'b0, first_fail}, 32'd0);
        chk({tag, "_sig"},  {16'b0, signature}, {16'b0, SEED});
    endtask

    // Pulse start, optionally pulse it again at cycle restart_at, and count
    // clocks (start edge included) until done is seen.
    task automatic run_sweep(input string tag, input int restart_at, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_at_start"}, {31'b0, busy}, 32'd1);
        chk({tag, "_cleared_err"}, {26'b0, err_cnt}, 32'd0);
        chk({tag, "_cleared_sig"}, {16'b0, signature}, {16'b0, SEED});
        while (!done && cyc < TIMEOUT) begin
            if (cyc == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        if (cyc >= TIMEOUT) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic chk_results(input string tag, input int cyc, input int exp_err,
                               input int exp_ff, input int m);
        chk({tag, "_len"},  cyc, SWEEP);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err"},  {26'b0, err_cnt}, exp_err);
        chk({tag, "_ff"},   {27'b0, first_fail}, exp_ff);
        chk({tag, "_pass"}, {31'b0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        chk({tag, "_sig"},  {16'b0, signature}, {16'b0, misr_model(m)});
        chk({tag, "_vec"},  {27'b0, a, b, c, d, e}, 32'd31);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_err_hold"}, {26'b0, err_cnt}, exp_err);
        chk({tag, "_pass_hold"}, {31'b0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic saw_done;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep and the three stuck-fault sweeps
        mode = 0; run_sweep("clean", -1, cyc); chk_results("clean", cyc, 0, 0, 0);
        mode = 1; run_sweep("z0", -1, cyc);    chk_results("z0", cyc, 31, 0, 1);
        mode = 2; run_sweep("x0", -1, cyc);    chk_results("x0", cyc, 3, 26, 2);
        mode = 3; run_sweep("y1", -1, cyc);    chk_results("y1", cyc, 1, 31, 3);

        // Start while busy is ignored
        mode = 2; run_sweep("restart", 20, cyc); chk_results("restart", cyc, 3, 26, 2);

        // Mid-sweep reset at vector 10
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while ({a, b, c, d, e} != 5'd10 && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrst_reach_vec10", {27'b0, a, b, c, d, e}, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        chk("midrst_no_done", {31'b0, saw_done}, 32'd0);
        chk("midrst_idle", {31'b0, busy}, 32'd0);

        run_sweep("post_rst", -1, cyc);
        chk_results("post_rst", cyc, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
